tilemap_scroll_sequencer: RTL and testbench

Per-pixel fetch sequencer and scroll controller for the dual-layer tilemap generator (`cus43`). It owns the CPU scroll registers for layers A and B and double-buffers them to frame boundaries. Each 4-pixel group, it time-multiplexes the tile VRAM and graphics ROM between the two layers. It drives the layer select (`CLK_2H`) and the scroll-phased shift-load strobes (`HA2`, `HB2`) that `cus43` consumes.

---
 rtl/tilemap_scroll_sequencer.sv | 112 +++++++++++
 tb/tb_tilemap_scroll_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tilemap_scroll_sequencer.sv
// Fetch sequencer and scroll controller for the dual-layer tilemap generator.
// Time-multiplexes tile VRAM and graphics ROM between layers A and B in 4-pixel groups.
module tilemap_scroll_sequencer #(
   parameter int VRAM_AW   = 12,
   parameter int H_PRELOAD = 4
) (
   input  logic               CLK_6M,
   input  logic               nRESET,
   input  logic [8:0]         H,
   input  logic [7:0]         V,
   input  logic               VBL_START,
   input  logic               FLIP,
   input  logic               CPU_WE,
   input  logic [2:0]         CPU_A,
   input  logic [7:0]         CPU_D,
   input  logic [15:0]        VRAM_D,
   output logic [VRAM_AW-1:0] VRAM_A,
   output logic [14:0]        GFX_A,
   output logic               LAYER,
   output logic               HA2,
   output logic               HB2
);

   logic [8:0]         r_sh_scrx_a, r_sh_scrx_b, r_scrx_a, r_scrx_b;
   logic [7:0]         r_sh_scry_a, r_sh_scry_b, r_scry_a, r_scry_b;
   logic [VRAM_AW-1:0] r_vram_a;
   logic [10:0]        r_code;
   logic [2:0]         r_fine;
   logic               r_half;
   logic               r_layer, r_ha2, r_hb2;

   logic [8:0] w_hf, w_ex_a, w_ex_b;
   logic [7:0] w_vf, w_ey_a, w_ey_b;
   logic       w_unused;

   assign w_hf   = FLIP ? ~H : H;
   assign w_vf   = FLIP ? ~V : V;
   assign w_ex_a = w_hf + 9'(H_PRELOAD) + r_scrx_a;
   assign w_ex_b = w_hf + 9'(H_PRELOAD) + r_scrx_b;
   assign w_ey_a = w_vf + r_scry_a;
   assign w_ey_b = w_vf + r_scry_b;

   // Attribute bits of the tile word are not used by the address path.
   assign w_unused = ^VRAM_D[15:11];

   always_ff @(posedge CLK_6M or negedge nRESET) begin
      if (!nRESET) begin
         r_sh_scrx_a <= '0;
         r_sh_scrx_b <= '0;
         r_sh_scry_a <= '0;
         r_sh_scry_b <= '0;
         r_scrx_a    <= '0;
         r_scrx_b    <= '0;
         r_scry_a    <= '0;
         r_scry_b    <= '0;
         r_vram_a    <= '0;
         r_code      <= '0;
         r_fine      <= '0;
         r_half      <= 1'b0;
         r_layer     <= 1'b0;
         r_ha2       <= 1'b0;
         r_hb2       <= 1'b0;
      end else begin
         if (CPU_WE) begin
            case (CPU_A)
               3'd0:    r_sh_scrx_a[7:0] <= CPU_D;
               3'd1:    r_sh_scrx_a[8]   <= CPU_D[0];
               3'd2:    r_sh_scry_a      <= CPU_D;
               3'd4:    r_sh_scrx_b[7:0] <= CPU_D;
               3'd5:    r_sh_scrx_b[8]   <= CPU_D[0];
               3'd6:    r_sh_scry_b      <= CPU_D;
               default: ;
            endcase
         end

         // NOTE: non-blocking updates make a coincident write land only in the
         // shadow while the frame copy below still picks up the old shadow value.
         if (VBL_START) begin
            r_scrx_a <= r_sh_scrx_a;
            r_scrx_b <= r_sh_scrx_b;
            r_scry_a <= r_sh_scry_a;
            r_scry_b <= r_sh_scry_b;
         end

         case (H[1:0])
            2'd0: r_vram_a <= VRAM_AW'({1'b0, w_ey_a[7:3], w_ex_a[8:3]});
            2'd1: begin
               r_code <= VRAM_D[10:0];
               r_fine <= w_ey_a[2:0];
               r_half <= w_ex_a[2];
            end
            2'd2: r_vram_a <= VRAM_AW'({1'b1, w_ey_b[7:3], w_ex_b[8:3]});
            default: begin
               r_code <= VRAM_D[10:0];
               r_fine <= w_ey_b[2:0];
               r_half <= w_ex_b[2];
            end
         endcase

         r_layer <= H[1];
         r_ha2   <= (H[1:0] + r_scrx_a[1:0]) == 2'd3;
         r_hb2   <= (H[1:0] + r_scrx_b[1:0]) == 2'd3;
      end
   end

   assign VRAM_A = r_vram_a;
   assign GFX_A  = {r_code, r_fine, r_half};
   assign LAYER  = r_layer;
   assign HA2    = r_ha2;
   assign HB2    = r_hb2;

endmodule

// File: tb/tb_tilemap_scroll_sequencer.sv
// Directed self-checking bench for tilemap_scroll_sequencer; expected values are hand-computed.
module tb_tilemap_scroll_sequencer;

   logic        CLK_6M = 1'b0;
   logic        nRESET = 1'b0;
   logic [8:0]  H = '0;
   logic [7:0]  V = '0;
   logic        VBL_START = 1'b0;
   logic        FLIP = 1'b0;
   logic        CPU_WE = 1'b0;
   logic [2:0]  CPU_A = '0;
   logic [7:0]  CPU_D = '0;
   logic [15:0] VRAM_D = '0;
   logic [11:0] VRAM_A;
   logic [14:0] GFX_A;
   logic        LAYER, HA2, HB2;

   int n_checks = 0;
   int n_pass   = 0;

   tilemap_scroll_sequencer #(.VRAM_AW(12), .H_PRELOAD(4)) dut (
      .CLK_6M(CLK_6M), .nRESET(nRESET), .H(H), .V(V), .VBL_START(VBL_START),
      .FLIP(FLIP), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_D(CPU_D), .VRAM_D(VRAM_D),
      .VRAM_A(VRAM_A), .GFX_A(GFX_A), .LAYER(LAYER), .HA2(HA2), .HB2(HB2)
   );

   always #5 CLK_6M = ~CLK_6M;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One pixel: H advances after the edge; VRAM returns the A tile in c=1, B tile in c=3.
   task automatic tick();
      @(posedge CLK_6M);
      #2;
      H = H + 9'd1;
      case (H[1:0])
         2'd1:    VRAM_D = 16'hF923;
         2'd3:    VRAM_D = 16'h0456;
         default: VRAM_D = 16'h0000;
      endcase
   endtask

   task automatic run_to(input logic [8:0] h);
      int k = 0;
      while (H != h && k < 1024) begin
         tick();
         k++;
      end
      if (H != h) check("run_to_timeout", 32'(H), 32'(h));
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
      CPU_WE = 1'b1; CPU_A = a; CPU_D = d;
      tick();
      CPU_WE = 1'b0;
   endtask

   task automatic vbl_pulse();
      VBL_START = 1'b1;
      tick();
      VBL_START = 1'b0;
   endtask

   initial begin
      // Reset held with H running
      repeat (3) tick();
      check("rst_vram_a", 32'(VRAM_A), 32'h0);
      check("rst_gfx_a",  32'(GFX_A),  32'h0);
      check("rst_layer",  32'(LAYER),  32'h0);
      check("rst_ha2",    32'(HA2),    32'h0);
      check("rst_hb2",    32'(HB2),    32'h0);
      nRESET = 1'b1;
      tick();                                   // H=4, edge used H=3
      check("rel_layer_h4", 32'(LAYER), 32'h1);
      check("rel_ha2_h4",   32'(HA2),   32'h1);
      tick();                                   // H=5, edge used H=4
      check("rel_vram_a_h5", 32'(VRAM_A), 32'h001);
      check("rel_layer_h5",  32'(LAYER),  32'h0);
      check("rel_ha2_h5",    32'(HA2),    32'h0);
      run_to(9'd7);                             // edge used H=6: B, col (10>>3)=1
      check("rel_vram_b_h7", 32'(VRAM_A), 32'h801);
      check("rel_layer_h7",  32'(LAYER),  32'h1);

      // Scroll A = 0x105 / 0x0A, not active until VBL_START
      cpu_write(3'd0, 8'h05);
      cpu_write(3'd1, 8'h01);
      cpu_write(3'd2, 8'h0A);
      cpu_write(3'd3, 8'hFF);
      cpu_write(3'd7, 8'hFF);
      run_to(9'd5);
      check("shadow_only_vram_a", 32'(VRAM_A), 32'h001);
      vbl_pulse();
      run_to(9'd1);
      check("scroll_a_vram_a", 32'(VRAM_A), 32'h061);
      tick();
      check("scroll_a_ha2_h2", 32'(HA2), 32'h0);
      tick();
      check("scroll_a_ha2_h3", 32'(HA2), 32'h1);
      check("scroll_a_hb2_h3", 32'(HB2), 32'h0);
      tick();
      check("scroll_a_ha2_h4", 32'(HA2), 32'h0);
      check("scroll_a_hb2_h4", 32'(HB2), 32'h1);

      // Code capture and GFX address hold (V=3: A fine 5, B fine 3)
      V = 8'd3;
      run_to(9'd18);
      check("gfx_a_h18", 32'(GFX_A), 32'h123A);
      tick();
      check("gfx_a_h19", 32'(GFX_A), 32'h123A);
      tick();
      check("gfx_b_h20", 32'(GFX_A), 32'h4567);
      tick();
      check("gfx_b_h21", 32'(GFX_A), 32'h4567);

      // X wrap on layer B: SCRX_B = 511
      cpu_write(3'd4, 8'hFF);
      cpu_write(3'd5, 8'h01);
      vbl_pulse();
      run_to(9'd1);
      check("wrap_hb2_h1", 32'(HB2), 32'h1);
      check("wrap_ha2_h1", 32'(HA2), 32'h0);
      run_to(9'd3);
      check("wrap_vram_b", 32'(VRAM_A), 32'h800);

      // CPU write coincident with VBL_START
      cpu_write(3'd6, 8'h20);
      CPU_WE = 1'b1; CPU_A = 3'd6; CPU_D = 8'h40; VBL_START = 1'b1;
      tick();
      CPU_WE = 1'b0; VBL_START = 1'b0;
      run_to(9'd3);
      check("coinc_old_scry_b", 32'(VRAM_A), 32'h900);
      vbl_pulse();
      run_to(9'd3);
      check("coinc_new_scry_b", 32'(VRAM_A), 32'hA00);

      // Asynchronous reset mid-frame clears outputs and scroll state
      run_to(9'd18);
      check("pre_rst_gfx_a", 32'(GFX_A), 32'h123A);
      #1 nRESET = 1'b0;
      #1;
      check("async_rst_gfx_a",  32'(GFX_A),  32'h0);
      check("async_rst_vram_a", 32'(VRAM_A), 32'h0);
      check("async_rst_layer",  32'(LAYER),  32'h0);
      tick();
      tick();
      nRESET = 1'b1;
      V = 8'd0;
      run_to(9'd5);
      check("post_rst_vram_a", 32'(VRAM_A), 32'h001);

      // Screen flip with scroll 0
      FLIP = 1'b1;
      run_to(9'd1);
      check("flip_vram_a", 32'(VRAM_A), 32'h7C0);
      run_to(9'd3);
      check("flip_vram_b", 32'(VRAM_A), 32'hFC0);
      tick();
      check("flip_ha2_h4", 32'(HA2), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
